bat_regfile: RTL and testbench
==============================

// Module: bat_regfile
// PURPOSE
//  Parametrised general-purpose register file for the BatAmateur CPU.
//  Replaces the fixed set of discrete bus registers (A, B, 3..7, OUT) with one block.
//  Sits between the controller's per-register strobes and the shared data bus.
//  Adds wrap flags, bus-conflict detection and a halt/debug access port.
// PARAMETERS
//  WIDTH      16             data width of every register and of the bus
//  NUM_REGS   8              number of registers (>=2)
//  ALU_A_IDX  0              register driven on ALU_A
//  ALU_B_IDX  1              register driven on ALU_B
//  OUT_IDX    NUM_REGS-1     register driven on OUT
//  IDX_W      $clog2(NUM_REGS) (localparam) debug index width
// PORTS
//  CLK        in   1         rising-edge clock
//  RST        in   1         synchronous reset, active low
//  BUS_IN     in   WIDTH     data bus value (sampled on writes)
//  BUS_OUT    out  WIDTH     value this block drives onto the bus
//  BUS_OE     out  1         drive enable for BUS_OUT; the top-level builds the tristate
//  WR_EN      in   NUM_REGS  per-register load from BUS_IN
//  RD_EN      in   NUM_REGS  per-register drive onto the bus (one-hot expected)
//  INC        in   NUM_REGS  per-register increment
//  CLR_WRAP   in   NUM_REGS  per-register clear of the WRAP flag
//  ALU_A      out  WIDTH     contents of reg ALU_A_IDX
//  ALU_B      out  WIDTH     contents of reg ALU_B_IDX
//  OUT        out  WIDTH     contents of reg OUT_IDX
//  WRAP       out  NUM_REGS  sticky flag: increment wrapped all-ones -> 0
//  BUS_CONFLICT out 1        high when more than one RD_EN bit is set
//  HALT       in   1         halt request
//  HALT_ACK   out  1         block is halted; CPU strobes are ignored
//  DBG_REQ    in   1         debug access request (4-phase handshake)
//  DBG_WE     in   1         1 = write, 0 = read
//  DBG_IDX    in   IDX_W     target register
//  DBG_WDATA  in   WIDTH     debug write data
//  DBG_RDATA  out  WIDTH     debug read data (registered); valid while DBG_ACK=1
//  DBG_ACK    out  1         debug access done
// BEHAVIOUR
//  Reset (RST=0 at a clock edge):
//   - Registers, WRAP, DBG_RDATA go to 0; DBG_ACK and HALT_ACK go to 0.
//   - State goes to RUN. This applies in any state, including mid-handshake.
//  Register update per cell, priority order: write > increment > hold.
//   - A write clears that cell's WRAP.
//   - An INC of all-ones gives 0 and sets WRAP.
//   - When both CLR_WRAP and a wrapping INC occur, the set wins.
//  Latency:
//   - A write or increment is visible on ALU_A/ALU_B/OUT/BUS_OUT one cycle after the edge.
//   - Read path is combinational from the current contents.
//   - Reading and writing the same register in one cycle drives the old value.
//  Bus read (RUN only):
//   - Exactly one RD_EN bit set -> BUS_OE=1 and BUS_OUT = that register.
//   - No bits set -> BUS_OE=0, BUS_OUT=0.
//   - Two or more bits set -> BUS_OE=0, BUS_OUT=0, BUS_CONFLICT=1 (combinational).
//  Several WR_EN bits set at once is legal: every selected register loads BUS_IN.
//  FSM states: RUN -> HALTED -> ACCESS.
//   RUN:
//    - CPU strobes are active.
//    - HALT=1 -> HALTED; that cycle's strobes still take effect.
//   HALTED:
//    - HALT_ACK=1. WR_EN/RD_EN/INC/CLR_WRAP are masked; BUS_OE=0.
//    - DBG_REQ=1 -> ACCESS. On that same edge the write is performed, or DBG_RDATA is loaded.
//    - Else HALT=0 -> RUN.
//   ACCESS:
//    - HALT_ACK=1, DBG_ACK=1, and only one access is made per request.
//    - Waits for DBG_REQ=0 and then goes to HALTED, even if HALT is already 0.
//  Out-of-range DBG_IDX (>= NUM_REGS): the write is dropped, DBG_RDATA=0, and ACK still completes.
//  DBG_REQ in RUN is ignored; DBG_ACK stays 0.
// STRUCTURE
//  Shared header bat_defs.vh holds:
//   - FSM encodings (BAT_RF_RUN=2'd0, BAT_RF_HALTED=2'd1, BAT_RF_ACCESS=2'd2).
//   - The default WIDTH.
//  Sub-module bat_reg_cell, one instance per register (generate loop):
//   - Inputs: WIDTH, load, load data, inc, clr_wrap.
//   - Outputs: q, wrap.
//  The debug write is muxed into cell i's load/load data.
//  Top level holds the FSM, RD_EN decode, conflict detect and debug read mux.
// TESTING
//  1. RST=0 after random traffic -> all registers 0, WRAP=0, HALT_ACK=0, BUS_OE=0.
//  2. Bus write/read:
//     - BUS_IN=16'h1234, WR_EN[2]=1, then RD_EN[2]=1 -> BUS_OUT=16'h1234, BUS_OE=1.
//     - Write reg 0 to 16'h00FF -> ALU_A=16'h00FF on the next cycle.
//  3. Wrap and priority:
//     - Reg 3 = 16'hFFFF, INC[3] -> 0, WRAP[3]=1.
//     - WR_EN[3]=1 with INC[3]=1 and BUS_IN=5 -> 5, WRAP[3]=0.
//  4. Conflict: RD_EN=8'b0000_0011 -> BUS_CONFLICT=1, BUS_OE=0, BUS_OUT=0.
//  5. Halt/debug:
//     - HALT=1 -> HALT_ACK after 1 cycle.
//     - Debug write 16'hBEEF to index 7 -> DBG_ACK=1; WR_EN to 7 while halted is ignored.
//     - Debug read of index 7 -> DBG_RDATA=16'hBEEF.
//     - DBG_REQ=0 -> back to HALTED; then HALT=0 -> RUN.
//     - OUT=16'hBEEF.
//  6. Edge cases:
//     - Reset during ACCESS -> DBG_ACK=0, state RUN, registers 0.
//     - Debug read of DBG_IDX >= NUM_REGS (NUM_REGS=6 build) -> DBG_RDATA=0 with ACK.

Source files
------------

// File: rtl/bat_regfile_pkg.sv
// Shared constants for the BatAmateur register file: default data width and
// the encodings of the halt/debug controller states.
package bat_regfile_pkg;

  localparam int BAT_DEFAULT_WIDTH = 16;

  localparam logic [1:0] BAT_RF_RUN    = 2'd0;
  localparam logic [1:0] BAT_RF_HALTED = 2'd1;
  localparam logic [1:0] BAT_RF_ACCESS = 2'd2;

endpackage

// File: rtl/bat_regfile_if.sv
// Bus, strobe and debug-port bundle between the CPU controller (master) and
// the register file (slave).
interface bat_regfile_if
  import bat_regfile_pkg::*;
#(
  parameter int WIDTH    = BAT_DEFAULT_WIDTH,
  parameter int NUM_REGS = 8
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [WIDTH-1:0]    bus_in;
  logic [WIDTH-1:0]    bus_out;
  logic                bus_oe;
  logic [NUM_REGS-1:0] wr_en;
  logic [NUM_REGS-1:0] rd_en;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] clr_wrap;
  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic [WIDTH-1:0]    out;
  logic [NUM_REGS-1:0] wrap;
  logic                bus_conflict;
  logic                halt;
  logic                halt_ack;
  logic                dbg_req;
  logic                dbg_we;
  logic [IDX_W-1:0]    dbg_idx;
  logic [WIDTH-1:0]    dbg_wdata;
  logic [WIDTH-1:0]    dbg_rdata;
  logic                dbg_ack;

  modport master (
    output bus_in, wr_en, rd_en, inc, clr_wrap, halt,
           dbg_req, dbg_we, dbg_idx, dbg_wdata,
    input  bus_out, bus_oe, alu_a, alu_b, out, wrap, bus_conflict,
           halt_ack, dbg_rdata, dbg_ack
  );

  modport slave (
    input  bus_in, wr_en, rd_en, inc, clr_wrap, halt,
           dbg_req, dbg_we, dbg_idx, dbg_wdata,
    output bus_out, bus_oe, alu_a, alu_b, out, wrap, bus_conflict,
           halt_ack, dbg_rdata, dbg_ack
  );

endinterface

// File: rtl/bat_regfile_cell.sv
// One register of the file: load beats increment beats hold, with a sticky
// flag recording an increment that rolled over from all-ones.
module bat_reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             inc,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_data;
      wrap <= 1'b0;
    end else if (inc) begin
      q <= q + WIDTH'(1);
      // a rollover on the same edge as a clear leaves the flag set
      if (&q)
        wrap <= 1'b1;
      else if (clr_wrap)
        wrap <= 1'b0;
    end else if (clr_wrap) begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/bat_regfile.sv
// BatAmateur general-purpose register file: per-register cells, bus read
// decode with conflict detection, and a halt/debug access controller.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | CPU strobes active; debug requests ignored
//   HALTED  | strobes masked, HALT_ACK=1; waiting for debug request or resume
//   ACCESS  | one debug access done, DBG_ACK=1; waiting for DBG_REQ to drop
module bat_regfile
  import bat_regfile_pkg::*;
#(
  parameter int WIDTH     = BAT_DEFAULT_WIDTH,
  parameter int NUM_REGS  = 8,
  parameter int ALU_A_IDX = 0,
  parameter int ALU_B_IDX = 1,
  parameter int OUT_IDX   = NUM_REGS - 1
) (
  input  logic clk,
  input  logic rst,
  bat_regfile_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                run;
  logic                dbg_fire;
  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [WIDTH-1:0]    cell_d [NUM_REGS];
  logic [NUM_REGS-1:0] wrap;
  logic [NUM_REGS-1:0] cell_ld;
  logic [NUM_REGS-1:0] dbg_hit;
  logic [NUM_REGS-1:0] rd_sel;
  logic                rd_multi;
  logic                rd_one;
  logic [WIDTH-1:0]    rd_val;
  logic [WIDTH-1:0]    dbg_val;
  logic [WIDTH-1:0]    dbg_rdata_q;

  assign run      = (state == BAT_RF_RUN);
  assign dbg_fire = (state == BAT_RF_HALTED) && bus.dbg_req;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
    // an out-of-range debug index matches no cell, so the write just drops
    assign dbg_hit[gi] = dbg_fire && bus.dbg_we && (bus.dbg_idx == IDX_W'(gi));
    assign cell_ld[gi] = (run && bus.wr_en[gi]) || dbg_hit[gi];
    assign cell_d[gi]  = dbg_hit[gi] ? bus.dbg_wdata : bus.bus_in;

    bat_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .load      (cell_ld[gi]),
      .load_data (cell_d[gi]),
      .inc       (run && bus.inc[gi]),
      .clr_wrap  (run && bus.clr_wrap[gi]),
      .q         (q[gi]),
      .wrap      (wrap[gi])
    );
  end

  assign rd_sel   = run ? bus.rd_en : '0;
  assign rd_multi = (rd_sel & (rd_sel - NUM_REGS'(1))) != '0;
  assign rd_one   = (rd_sel != '0) && !rd_multi;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_sel[i]) rd_val = rd_val | q[i];
  end

  always_comb begin
    dbg_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.dbg_idx == IDX_W'(i)) dbg_val = q[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BAT_RF_RUN:    if (bus.halt) state_nxt = BAT_RF_HALTED;
      BAT_RF_HALTED: if (bus.dbg_req) state_nxt = BAT_RF_ACCESS;
                     else if (!bus.halt) state_nxt = BAT_RF_RUN;
      BAT_RF_ACCESS: if (!bus.dbg_req) state_nxt = BAT_RF_HALTED;
      default:       state_nxt = BAT_RF_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BAT_RF_RUN;
      dbg_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (dbg_fire && !bus.dbg_we)
        dbg_rdata_q <= dbg_val;
    end
  end

  assign bus.bus_out      = rd_one ? rd_val : '0;
  assign bus.bus_oe       = rd_one;
  assign bus.bus_conflict = rd_multi;
  assign bus.alu_a        = q[ALU_A_IDX];
  assign bus.alu_b        = q[ALU_B_IDX];
  assign bus.out          = q[OUT_IDX];
  assign bus.wrap         = wrap;
  assign bus.halt_ack     = !run;
  assign bus.dbg_ack      = (state == BAT_RF_ACCESS);
  assign bus.dbg_rdata    = dbg_rdata_q;

endmodule

// File: tb/tb_bat_regfile.sv
// Self-checking bench for bat_regfile: directed scenarios plus random traffic
// compared against a behavioural model of the register file.
module tb_bat_regfile;

  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bat_regfile_if #(.WIDTH(W), .NUM_REGS(N)) bif();
  bat_regfile_if #(.WIDTH(W), .NUM_REGS(6)) bif6();

  bat_regfile #(.WIDTH(W), .NUM_REGS(N)) dut (.clk(clk), .rst(rst), .bus(bif));
  bat_regfile #(.WIDTH(W), .NUM_REGS(6)) dut6 (.clk(clk), .rst(rst), .bus(bif6));

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: 0 = running, 1 = halted, 2 = access in progress
  logic [W-1:0] m_reg [N];
  logic [N-1:0] m_wrap;
  logic [W-1:0] m_rdata;
  int           m_state;

  task automatic model_edge();
    logic [W:0] sum;
    if (!rst) begin
      for (int i = 0; i < N; i++) m_reg[i] = '0;
      m_wrap = '0; m_rdata = '0; m_state = 0;
    end else if (m_state == 0) begin
      for (int i = 0; i < N; i++) begin
        if (bif.wr_en[i]) begin
          m_reg[i] = bif.bus_in; m_wrap[i] = 1'b0;
        end else if (bif.inc[i]) begin
          sum = {1'b0, m_reg[i]} + 1;
          m_reg[i] = sum[W-1:0];
          if (sum[W]) m_wrap[i] = 1'b1;
          else if (bif.clr_wrap[i]) m_wrap[i] = 1'b0;
        end else if (bif.clr_wrap[i]) begin
          m_wrap[i] = 1'b0;
        end
      end
      if (bif.halt) m_state = 1;
    end else if (m_state == 1) begin
      if (bif.dbg_req) begin
        if (bif.dbg_we) begin
          if (int'(bif.dbg_idx) < N) begin
            m_reg[bif.dbg_idx] = bif.dbg_wdata; m_wrap[bif.dbg_idx] = 1'b0;
          end
        end else begin
          m_rdata = (int'(bif.dbg_idx) < N) ? m_reg[bif.dbg_idx] : '0;
        end
        m_state = 2;
      end else if (!bif.halt) m_state = 0;
    end else begin
      if (!bif.dbg_req) m_state = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.bus_in = '0; bif.wr_en = '0; bif.rd_en = '0; bif.inc = '0; bif.clr_wrap = '0;
    bif.dbg_req = 1'b0; bif.dbg_we = 1'b0; bif.dbg_idx = '0; bif.dbg_wdata = '0;
  endtask

  task automatic test_random(input int cycles);
    int cnt;
    logic [W-1:0] exp_out;
    for (int c = 0; c < cycles; c++) begin
      bif.bus_in   = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
      bif.wr_en    = N'($urandom & $urandom & $urandom);
      bif.inc      = N'($urandom & $urandom);
      bif.clr_wrap = N'($urandom & $urandom);
      case ($urandom_range(0, 3))
        0:       bif.rd_en = '0;
        1, 2:    bif.rd_en = N'(1) << $urandom_range(0, N - 1);
        default: bif.rd_en = N'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) bif.halt = !bif.halt;
      bif.dbg_req   = ($urandom_range(0, 2) == 0);
      bif.dbg_we    = 1'($urandom);
      bif.dbg_idx   = 3'($urandom);
      bif.dbg_wdata = W'($urandom);
      #1;
      cnt = (m_state == 0) ? $countones(bif.rd_en) : 0;
      exp_out = '0;
      if (cnt == 1)
        for (int i = 0; i < N; i++) if (bif.rd_en[i]) exp_out = m_reg[i];
      n_checks++;
      if (bif.bus_oe !== (cnt == 1) || bif.bus_out !== exp_out || bif.bus_conflict !== (cnt > 1)) begin
        n_fail++;
        $display("FAIL rand_bus: oe=%b out=%h conf=%b, want oe=%b out=%h conf=%b",
                 bif.bus_oe, bif.bus_out, bif.bus_conflict, cnt == 1, exp_out, cnt > 1);
      end
      tick();
      n_checks++;
      if (bif.alu_a !== m_reg[0] || bif.alu_b !== m_reg[1] || bif.out !== m_reg[N-1] || bif.wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL rand_regs: a=%h b=%h out=%h wrap=%b, want a=%h b=%h out=%h wrap=%b",
                 bif.alu_a, bif.alu_b, bif.out, bif.wrap, m_reg[0], m_reg[1], m_reg[N-1], m_wrap);
      end
      n_checks++;
      if (bif.halt_ack !== (m_state != 0) || bif.dbg_ack !== (m_state == 2) || bif.dbg_rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL rand_ctrl: hack=%b dack=%b rdata=%h, want hack=%b dack=%b rdata=%h",
                 bif.halt_ack, bif.dbg_ack, bif.dbg_rdata, m_state != 0, m_state == 2, m_rdata);
      end
    end
    idle();
    bif.halt = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    bif.wr_en = N'($urandom); bif.inc = N'($urandom); bif.bus_in = W'($urandom);
    bif.halt = 1'b1; bif.dbg_req = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle();
    bif.halt = 1'b0;
    n_checks++;
    if (bif.alu_a !== '0 || bif.alu_b !== '0 || bif.out !== '0 || bif.wrap !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: a=%h b=%h out=%h wrap=%b, want all 0", bif.alu_a, bif.alu_b, bif.out, bif.wrap);
    end
    n_checks++;
    if (bif.halt_ack !== 1'b0 || bif.dbg_ack !== 1'b0 || bif.dbg_rdata !== '0 || bif.bus_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: hack=%b dack=%b rdata=%h oe=%b, want 0", bif.halt_ack, bif.dbg_ack, bif.dbg_rdata, bif.bus_oe);
    end
    for (int i = 0; i < N; i++) begin
      bif.rd_en = N'(1) << i;
      #1;
      n_checks++;
      if (bif.bus_out !== '0 || bif.bus_oe !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_reg%0d: out=%h oe=%b, want 0000 and 1", i, bif.bus_out, bif.bus_oe);
      end
    end
    idle();
  endtask

  task automatic test_bus_rw();
    bif.bus_in = 16'h1234; bif.wr_en = 8'h04;
    tick();
    idle();
    bif.rd_en = 8'h04;
    #1;
    n_checks++;
    if (bif.bus_out !== 16'h1234 || bif.bus_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_reg2: out=%h oe=%b, want 1234 and 1", bif.bus_out, bif.bus_oe);
    end
    idle();
    bif.bus_in = 16'h00FF; bif.wr_en = 8'h01;
    tick();
    idle();
    n_checks++;
    if (bif.alu_a !== 16'h00FF) begin
      n_fail++;
      $display("FAIL rw_alu_a: got %h want 00FF", bif.alu_a);
    end
    bif.bus_in = 16'h7777; bif.wr_en = 8'h60;
    tick();
    idle();
    for (int i = 5; i <= 6; i++) begin
      bif.rd_en = N'(1) << i;
      #1;
      n_checks++;
      if (bif.bus_out !== 16'h7777) begin
        n_fail++;
        $display("FAIL rw_multi%0d: got %h want 7777", i, bif.bus_out);
      end
    end
    idle();
  endtask

  task automatic test_wrap();
    bif.bus_in = 16'hFFFF; bif.wr_en = 8'h08;
    tick();
    idle();
    bif.inc = 8'h08;
    tick();
    idle();
    bif.rd_en = 8'h08;
    #1;
    n_checks++;
    if (bif.bus_out !== 16'h0000 || bif.wrap[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_set: out=%h wrap3=%b, want 0000 and 1", bif.bus_out, bif.wrap[3]);
    end
    idle();
    bif.wr_en = 8'h08; bif.inc = 8'h08; bif.bus_in = 16'h0005;
    tick();
    idle();
    bif.rd_en = 8'h08;
    #1;
    n_checks++;
    if (bif.bus_out !== 16'h0005 || bif.wrap[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_prio: out=%h wrap3=%b, want 0005 and 0", bif.bus_out, bif.wrap[3]);
    end
    idle();
    bif.bus_in = 16'hFFFF; bif.wr_en = 8'h08;
    tick();
    idle();
    bif.inc = 8'h08; bif.clr_wrap = 8'h08;
    tick();
    idle();
    n_checks++;
    if (bif.wrap[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_set_wins: got %b want 1", bif.wrap[3]);
    end
    bif.clr_wrap = 8'h08;
    tick();
    idle();
    n_checks++;
    if (bif.wrap[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clear: got %b want 0", bif.wrap[3]);
    end
    bif.rd_en = 8'h08; bif.wr_en = 8'h08; bif.bus_in = 16'hAAAA;
    #1;
    n_checks++;
    if (bif.bus_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rw_same_cycle: got %h want 0000", bif.bus_out);
    end
    tick();
    idle();
    bif.rd_en = 8'h08;
    #1;
    n_checks++;
    if (bif.bus_out !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL rw_after: got %h want AAAA", bif.bus_out);
    end
    idle();
  endtask

  task automatic test_conflict();
    bif.rd_en = 8'b0000_0011;
    #1;
    n_checks++;
    if (bif.bus_conflict !== 1'b1 || bif.bus_oe !== 1'b0 || bif.bus_out !== '0) begin
      n_fail++;
      $display("FAIL conflict: conf=%b oe=%b out=%h, want 1 0 0000", bif.bus_conflict, bif.bus_oe, bif.bus_out);
    end
    bif.rd_en = '0;
    #1;
    n_checks++;
    if (bif.bus_conflict !== 1'b0 || bif.bus_oe !== 1'b0 || bif.bus_out !== '0) begin
      n_fail++;
      $display("FAIL no_read: conf=%b oe=%b out=%h, want 0 0 0000", bif.bus_conflict, bif.bus_oe, bif.bus_out);
    end
  endtask

  task automatic test_halt_debug();
    logic [W-1:0] a_before;
    bif.halt = 1'b1;
    tick();
    n_checks++;
    if (bif.halt_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_ack: got %b want 1", bif.halt_ack);
    end
    bif.rd_en = 8'h80;
    #1;
    n_checks++;
    if (bif.bus_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL halted_oe: got %b want 0", bif.bus_oe);
    end
    bif.wr_en = 8'h80; bif.bus_in = 16'h1111;
    bif.dbg_req = 1'b1; bif.dbg_we = 1'b1; bif.dbg_idx = 3'd7; bif.dbg_wdata = 16'hBEEF;
    tick();
    n_checks++;
    if (bif.dbg_ack !== 1'b1 || bif.out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL dbg_write: ack=%b out=%h, want 1 and BEEF", bif.dbg_ack, bif.out);
    end
    bif.dbg_wdata = 16'hDEAD;
    tick();
    n_checks++;
    if (bif.dbg_ack !== 1'b1 || bif.out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL dbg_single: ack=%b out=%h, want 1 and BEEF", bif.dbg_ack, bif.out);
    end
    bif.dbg_req = 1'b0;
    tick();
    n_checks++;
    if (bif.dbg_ack !== 1'b0 || bif.halt_ack !== 1'b1 || bif.out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL dbg_release: ack=%b hack=%b out=%h, want 0 1 BEEF", bif.dbg_ack, bif.halt_ack, bif.out);
    end
    bif.dbg_req = 1'b1; bif.dbg_we = 1'b0; bif.dbg_idx = 3'd7;
    tick();
    n_checks++;
    if (bif.dbg_rdata !== 16'hBEEF || bif.dbg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL dbg_read: rdata=%h ack=%b, want BEEF and 1", bif.dbg_rdata, bif.dbg_ack);
    end
    idle();
    tick();
    bif.halt = 1'b0;
    tick();
    n_checks++;
    if (bif.halt_ack !== 1'b0 || bif.out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL resume: hack=%b out=%h, want 0 and BEEF", bif.halt_ack, bif.out);
    end
    a_before = m_reg[0];
    bif.dbg_req = 1'b1; bif.dbg_we = 1'b1; bif.dbg_idx = 3'd0; bif.dbg_wdata = ~a_before;
    tick();
    idle();
    n_checks++;
    if (bif.dbg_ack !== 1'b0 || bif.alu_a !== a_before) begin
      n_fail++;
      $display("FAIL dbg_in_run: ack=%b a=%h, want 0 and %h", bif.dbg_ack, bif.alu_a, a_before);
    end
  endtask

  task automatic test_reset_access();
    bif.halt = 1'b1;
    tick();
    bif.dbg_req = 1'b1; bif.dbg_we = 1'b1; bif.dbg_idx = 3'd2; bif.dbg_wdata = 16'h4321;
    tick();
    n_checks++;
    if (bif.dbg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL access_enter: ack=%b want 1", bif.dbg_ack);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle();
    bif.halt = 1'b0;
    bif.rd_en = 8'h04;
    #1;
    n_checks++;
    if (bif.dbg_ack !== 1'b0 || bif.halt_ack !== 1'b0 || bif.bus_oe !== 1'b1 || bif.bus_out !== '0 || bif.out !== '0) begin
      n_fail++;
      $display("FAIL reset_access: dack=%b hack=%b oe=%b bus=%h out=%h, want 0 0 1 0000 0000",
               bif.dbg_ack, bif.halt_ack, bif.bus_oe, bif.bus_out, bif.out);
    end
    idle();
  endtask

  task automatic dbg6(input logic we, input logic [2:0] idx, input logic [W-1:0] wd);
    bif6.dbg_req = 1'b1; bif6.dbg_we = we; bif6.dbg_idx = idx; bif6.dbg_wdata = wd;
    tick();
    bif6.dbg_req = 1'b0;
  endtask

  task automatic test_oor();
    bif6.halt = 1'b1;
    tick();
    dbg6(1'b1, 3'd5, 16'hABCD);
    tick();
    dbg6(1'b0, 3'd5, '0);
    n_checks++;
    if (bif6.dbg_rdata !== 16'hABCD) begin
      n_fail++;
      $display("FAIL n6_read5: got %h want ABCD", bif6.dbg_rdata);
    end
    tick();
    dbg6(1'b0, 3'd6, '0);
    n_checks++;
    if (bif6.dbg_rdata !== '0 || bif6.dbg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL n6_read_oor: rdata=%h ack=%b, want 0000 and 1", bif6.dbg_rdata, bif6.dbg_ack);
    end
    tick();
    n_checks++;
    if (bif6.dbg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL n6_ack_drop: got %b want 0", bif6.dbg_ack);
    end
    dbg6(1'b1, 3'd7, 16'h5555);
    n_checks++;
    if (bif6.dbg_ack !== 1'b1 || bif6.out !== 16'hABCD) begin
      n_fail++;
      $display("FAIL n6_write_oor: ack=%b out=%h, want 1 and ABCD", bif6.dbg_ack, bif6.out);
    end
    tick();
    bif6.halt = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    bif.halt = 1'b0;
    bif6.bus_in = '0; bif6.wr_en = '0; bif6.rd_en = '0; bif6.inc = '0; bif6.clr_wrap = '0;
    bif6.halt = 1'b0; bif6.dbg_req = 1'b0; bif6.dbg_we = 1'b0; bif6.dbg_idx = '0; bif6.dbg_wdata = '0;
    #1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    test_random(300);
    test_reset();
    test_bus_rw();
    test_wrap();
    test_conflict();
    test_halt_debug();
    test_reset_access();
    test_oor();
    test_random(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish before 200000");
    $fatal(1);
  end

endmodule
